// File: rtl/tpu_skew_feeder_if.sv
// Operand-feed and array-edge signals between a vector source, the skew feeder and the systolic array.
// slave = feeder side, master = source/array side.
interface tpu_skew_feeder_if #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DIM*BITS_AB-1:0]   in_vec;
  logic                     stall;
  logic [DIM*BITS_AB-1:0]   out_vec;
  logic                     out_en;
  logic                     done;

  modport slave (
    input  in_valid, in_vec, stall,
    output in_ready, out_vec, out_en, done
  );

  modport master (
    output in_valid, in_vec, stall,
    input  in_ready, out_vec, out_en, done
  );
endinterface

// File: rtl/tpu_skew_feeder.sv
// Buffers a DIM-vector tile, then streams it diagonally skewed (lane i delayed by i) into a systolic array edge.
// All outputs registered; a stall sampled in a cycle holds t/out_vec and clears out_en from the next cycle.
module tpu_skew_feeder #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tpu_skew_feeder_if.slave     io
);
  localparam int TW = $clog2(2*DIM);
  localparam int CW = $clog2(DIM);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [TW-1:0]           t_q;
  logic [TW-1:0]           t_d;
  logic [BITS_AB-1:0]      vec_buf_q [DIM][DIM];
  logic [DIM*BITS_AB-1:0]  out_vec_q;
  logic [DIM*BITS_AB-1:0]  skew_d;
  logic                    out_en_q;
  logic                    done_q;
  logic                    in_ready_q;
  logic                    hs;

  assign hs = io.in_valid && in_ready_q;

  // Index of the diagonal that will be on the outputs after this edge.
  assign t_d = (state_q == STREAM) ? t_q + TW'(1) : '0;

  always_comb begin
    skew_d = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (int'(t_d) == k + i) begin
          skew_d[i*BITS_AB +: BITS_AB] = vec_buf_q[k][i];
        end
      end
    end
  end

  // Tile storage is deliberately not reset; a new tile always overwrites from V_0.
  always_ff @(posedge clk) begin
    if (hs) begin
      for (int i = 0; i < DIM; i++) begin
        vec_buf_q[cnt_q][i] <= io.in_vec[i*BITS_AB +: BITS_AB];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      t_q        <= '0;
      out_vec_q  <= '0;
      out_en_q   <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      out_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (hs) begin
            if (cnt_q == CW'(DIM-1)) begin
              state_q    <= STREAM;
              cnt_q      <= '0;
              t_q        <= '0;
              out_vec_q  <= skew_d;
              out_en_q   <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= LOAD;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        STREAM: begin
          if (!io.stall) begin
            if (t_q == TW'(2*DIM-2)) begin
              state_q   <= DONE;
              out_vec_q <= '0;
              done_q    <= 1'b1;
            end else begin
              t_q       <= t_d;
              out_vec_q <= skew_d;
              out_en_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          t_q        <= '0;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign io.in_ready = in_ready_q;
  assign io.out_vec  = out_vec_q;
  assign io.out_en   = out_en_q;
  assign io.done     = done_q;

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Directed tile scenarios plus randomized traffic, checked each cycle against a tile-level reference model.
module tb_tpu_skew_feeder;
  localparam int DIM = 4;
  localparam int B   = 8;
  localparam int W   = DIM*B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_skew_feeder_if #(.DIM(DIM), .BITS_AB(B)) bus();

  tpu_skew_feeder #(.DIM(DIM), .BITS_AB(B)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  // Reference model: the tile as a plain array, plus which diagonal is showing.
  typedef enum int {M_IDLE, M_LOAD, M_STREAM, M_DONE} mphase_e;
  mphase_e     m_phase = M_IDLE;
  int          m_cnt = 0;
  int          m_t = 0;
  logic [7:0]  m_tile [DIM][DIM];
  logic [W-1:0] e_vec = '0;
  logic        e_en = 1'b0;
  logic        e_done = 1'b0;
  logic        e_rdy = 1'b1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] skew_of(input int t);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      if (t - i >= 0 && t - i < DIM) v[i*B +: B] = m_tile[t-i][i];
    end
    return v;
  endfunction

  function automatic logic [W-1:0] vec_a(input int k);
    logic [W-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*B +: B] = 8'(16*k + i);
    return v;
  endfunction

  task automatic model_step();
    e_en   = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_phase = M_IDLE; m_cnt = 0; m_t = 0;
      e_vec = '0; e_rdy = 1'b1;
      return;
    end
    case (m_phase)
      M_IDLE, M_LOAD: begin
        if (bus.in_valid && e_rdy) begin
          for (int i = 0; i < DIM; i++) m_tile[m_cnt][i] = bus.in_vec[i*B +: B];
          m_cnt++;
          m_phase = M_LOAD;
          if (m_cnt == DIM) begin
            m_phase = M_STREAM; m_cnt = 0; m_t = 0;
            e_vec = skew_of(0); e_en = 1'b1; e_rdy = 1'b0;
          end
        end
      end
      M_STREAM: begin
        if (!bus.stall) begin
          if (m_t == 2*DIM-2) begin
            m_phase = M_DONE; e_vec = '0; e_done = 1'b1;
          end else begin
            m_t++; e_vec = skew_of(m_t); e_en = 1'b1;
          end
        end
      end
      default: begin
        m_phase = M_IDLE; e_rdy = 1'b1;
      end
    endcase
  endtask

  task automatic tick(input logic v, input logic [W-1:0] vec, input logic st, input logic r);
    rst = r; bus.in_valid = v; bus.in_vec = vec; bus.stall = st;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("in_ready", W'(bus.in_ready), W'(e_rdy));
    check("out_en",   W'(bus.out_en),   W'(e_en));
    check("done",     W'(bus.done),     W'(e_done));
    check("out_vec",  bus.out_vec,      e_vec);
    if (bus.out_en) en_cnt++;
    if (bus.done) done_cnt++;
  endtask

  task automatic run_to_done(input string tag);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, '0, 1'b0, 1'b0);
      if (bus.done) begin
        tick(1'b0, '0, 1'b0, 1'b0);
        return;
      end
    end
    check(tag, W'(bus.done), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_vec = '0; bus.stall = 1'b0;
    @(negedge clk);
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back load then a full stream.
    en_cnt = 0; done_cnt = 0;
    for (int k = 0; k < DIM; k++) tick(1'b1, vec_a(k), 1'b0, 1'b0);
    check("A_t0_vec", bus.out_vec, 32'h0000_0000);
    check("A_t0_en", W'(bus.out_en), W'(1));
    for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b0, 1'b0);
    check("A_t3_vec", bus.out_vec, 32'h0312_2130);
    for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b0, 1'b0);
    check("A_t6_vec", bus.out_vec, 32'h3300_0000);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("A_done", W'(bus.done), W'(1));
    tick(1'b0, '0, 1'b0, 1'b0);
    check("A_en_total", W'(en_cnt), W'(7));
    check("A_done_total", W'(done_cnt), W'(1));

    // Alternating in_valid: four handshakes over seven cycles.
    for (int c = 0; c < 7; c++) begin
      tick((c % 2) == 0, vec_a(c / 2), 1'b0, 1'b0);
      if (c == 5) check("B_not_yet", W'(bus.out_en), W'(0));
    end
    check("B_stream_start", W'(bus.out_en), W'(1));
    run_to_done("B_timeout");

    // Two-cycle stall while t=2 is on the outputs.
    en_cnt = 0;
    for (int k = 0; k < DIM; k++) tick(1'b1, vec_a(k), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    check("C_t2_vec", bus.out_vec, 32'h0002_1120);
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      check("C_stall_vec", bus.out_vec, 32'h0002_1120);
      check("C_stall_en", W'(bus.out_en), W'(0));
    end
    run_to_done("C_timeout");
    check("C_en_total", W'(en_cnt), W'(7));

    // Reset pulse at t=4, then a fresh random tile.
    for (int k = 0; k < DIM; k++) tick(1'b1, vec_a(k), 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1);
    check("D_rst_en", W'(bus.out_en), W'(0));
    check("D_rst_vec", bus.out_vec, 32'h0);
    check("D_rst_rdy", W'(bus.in_ready), W'(1));
    en_cnt = 0;
    for (int k = 0; k < DIM; k++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
    run_to_done("D_timeout");
    check("D_en_total", W'(en_cnt), W'(7));

    // in_valid held high across two tiles.
    for (int k = 0; k < DIM; k++) tick(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 20 && !bus.done; c++) begin
      tick(1'b1, W'($urandom), 1'b0, 1'b0);
      if (bus.out_en || bus.done) check("E_rdy_busy", W'(bus.in_ready), W'(0));
    end
    begin
      int gap;
      gap = 0;
      for (int c = 0; c < 10 && !bus.out_en; c++) begin
        tick(1'b1, W'($urandom), 1'b0, 1'b0);
        gap++;
      end
      check("E_gap", W'(gap), W'(5));
    end
    run_to_done("E_timeout");

    // Negative operands pass unchanged.
    for (int k = 0; k < DIM; k++) tick(1'b1, {DIM{8'(8'h80 | k)}}, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b0, 1'b0);
    check("F_t3_vec", bus.out_vec, 32'h8081_8283);
    run_to_done("F_timeout");

    // Randomized traffic with occasional stalls and resets.
    for (int c = 0; c < 1500; c++) begin
      tick($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tpu_skew_feeder.md
TPU_SKEW_FEEDER -- requirements
Module: tpu_skew_feeder

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning the systolic array dimension (lanes per vector, vectors per tile); legal range 2..16.
REQ-002 SHALL have parameter BITS_AB, default 8, meaning the signed operand width per lane, matching the MAC cell A/B width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_vec carries a valid operand vector.
REQ-006 SHALL have port in_ready, output, 1 bit: the feeder accepts in_vec this cycle.
REQ-007 SHALL have port in_vec, input, DIM*BITS_AB bits: lane i occupies bits [i*BITS_AB +: BITS_AB].
REQ-008 SHALL have port stall, input, 1 bit: the downstream array requests a hold.
REQ-009 SHALL have port out_vec, output, DIM*BITS_AB bits: the skewed operand vector for the array edge (lane i drives row/column i Ain/Bin).
REQ-010 SHALL have port out_en, output, 1 bit: drives the MAC cell en; out_vec is valid for consumption this cycle.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at tile completion.

Function
REQ-012 SHALL implement states IDLE, LOAD, STREAM and DONE.
REQ-013 SHALL complete a handshake when in_valid and in_ready are both 1 in the same cycle; in_ready SHALL be 1 in IDLE and LOAD and 0 in STREAM and DONE.
REQ-014 SHALL store the k-th accepted vector of a tile as V_k (k = 0..DIM-1) in an internal DIM x DIM x BITS_AB buffer; the first handshake in IDLE SHALL store V_0 and move to LOAD.
REQ-015 SHALL move from LOAD to STREAM on the handshake of V_(DIM-1); the load count SHALL not advance in cycles without a handshake (gaps allowed).
REQ-016 SHALL keep a stream counter t, $clog2(2*DIM) bits wide, equal to 0 on entry to STREAM; STREAM SHALL last 2*DIM-1 non-stalled cycles (t = 0..2*DIM-2).
REQ-017 SHALL, in STREAM with stall = 0, drive lane i of out_vec = V_(t-i)[i] if 0 <= t-i <= DIM-1, else 0, assert out_en = 1, and advance t by 1.
REQ-018 SHALL, in STREAM with stall = 1, hold t and out_vec unchanged and drive out_en = 0.
REQ-019 SHALL pass operand values bit-exact (no sign extension, saturation or arithmetic).
REQ-020 SHALL move from STREAM to DONE after the non-stalled cycle with t = 2*DIM-2; DONE SHALL last exactly one cycle with done = 1, out_en = 0 and out_vec = 0, then return to IDLE.
REQ-021 SHALL drive out_en = 0 and out_vec = 0 in IDLE, LOAD and DONE.
REQ-022 SHALL register out_vec, out_en, done and in_ready (no combinational path from in_valid or stall to any output).
REQ-023 SHALL ignore in_valid in STREAM and DONE (no buffer write).
REQ-024 SHALL accept the first vector of the next tile in the IDLE cycle that follows DONE.

Reset
REQ-025 SHALL, while rst = 1, force state IDLE, load count 0, t = 0, out_vec = 0, out_en = 0 and done = 0; in_ready SHALL read 1 in the first cycle after rst deasserts.
REQ-026 SHALL, on rst asserted mid-LOAD or mid-STREAM, abandon the partial tile; the next tile SHALL start at V_0. Buffer contents need not be cleared.

Verification (DIM=4, BITS_AB=8, V_k[i] = 16*k+i)
REQ-027 SHALL cover back-to-back load of 4 vectors followed by a stream: t=0 out_vec lanes {0x00,0,0,0}; t=3 lanes {0x30,0x21,0x12,0x03}; t=6 lanes {0,0,0,0x33}; out_en high for exactly 7 cycles, then done for 1 cycle.
REQ-028 SHALL cover in_valid toggling 1,0,1,0,...: exactly 4 handshakes fill the tile, and STREAM starts the cycle after the 4th.
REQ-029 SHALL cover stall = 1 for 2 cycles at t=2: out_vec holds lanes {0x20,0x11,0x02,0}, out_en = 0 during the stall, and out_en still totals 7 cycles.
REQ-030 SHALL cover rst pulsed at t=4: the next cycle shows out_en = 0, out_vec = 0, in_ready = 1, and a fresh 4-vector tile then streams correctly.
REQ-031 SHALL cover two back-to-back tiles with in_valid held high: in_ready = 0 throughout STREAM and DONE, and the first vector of tile 2 is accepted in the IDLE cycle after done.
REQ-032 SHALL cover negative operands (V_k[i] = 0x80 | k): values appear unchanged on the diagonal positions.
